sram_controller: RTL and testbench

- Sits directly downstream of the MEM stage. It converts the stage's single-cycle 32-bit data-memory request into a multi-cycle access to an external 16-bit asynchronous SRAM.
- Each 32-bit word occupies two half-words: low half first, then high half.
- Drives `ready`; the pipeline top freezes all stages (PC, IFID, IDEXE, EXEMEM, MEMWB) while `ready`=0.

---
 rtl/sram_controller.sv | 183 ++++++++++++++++++
 tb/tb_sram_controller.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges the MEM stage's single-cycle 32-bit data request to a 16-bit asynchronous SRAM.
// Each word is accessed as two half-word phases, low half first; `ready` low freezes the pipeline.
//
// state  | meaning
// IDLE   | waiting for a request; latches op/address/data when one arrives
// LOW    | low half-word phase, WAIT_CYCLES+1 cycles
// HIGH   | high half-word phase, WAIT_CYCLES+1 cycles
// DONE   | strobes released, ready=1 for one cycle, then back to IDLE
module sram_controller #(
  parameter int          ADDR_W      = 18,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              ready,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_dq_out,
  input  logic [15:0]       sram_dq_in,
  output logic              sram_dq_oe,
  output logic              sram_we_n,
  output logic              sram_oe_n
);

  localparam int               CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              op_wr, op_wr_nxt;
  logic [31:0]       addr_q, addr_nxt;
  logic [31:0]       wdata_q, wdata_nxt;

  logic              req;
  logic              phase_end;
  logic              capture_lo;
  logic              capture_hi;
  logic [ADDR_W-1:0] hw_lo;

  logic [ADDR_W-1:0] sram_addr_nxt;
  logic [15:0]       dq_out_nxt;
  logic              dq_oe_nxt;
  logic              we_n_nxt;
  logic              oe_n_nxt;

  assign req        = wr_en | rd_en;
  assign phase_end  = (cnt == '0);
  assign ready      = (state == S_DONE) || ((state == S_IDLE) && !req);
  assign capture_lo = (state == S_LOW)  && phase_end && !op_wr;
  assign capture_hi = (state == S_HIGH) && phase_end && !op_wr;

  // Phase timer is a down-counter loaded on phase entry; terminal count ends the phase.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_wr_nxt = op_wr;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = S_LOW;
          cnt_nxt   = CNT_LOAD;
          op_wr_nxt = wr_en;
          addr_nxt  = address;
          wdata_nxt = write_data;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          state_nxt = S_HIGH;
          cnt_nxt   = CNT_LOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          state_nxt = S_DONE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // SRAM pins are registered: they are computed for the state being entered so they
  // are stable for the whole phase, and strobes drop together on leaving HIGH.
  always_comb begin
    hw_lo         = ADDR_W'(((addr_nxt - BASE_ADDR) >> 2) << 1);
    sram_addr_nxt = sram_addr;
    dq_out_nxt    = sram_dq_out;
    dq_oe_nxt     = 1'b0;
    we_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    case (state_nxt)
      S_LOW: begin
        sram_addr_nxt = hw_lo;
        if (op_wr_nxt) begin
          dq_out_nxt = wdata_nxt[15:0];
          dq_oe_nxt  = 1'b1;
          we_n_nxt   = 1'b0;
        end else begin
          oe_n_nxt = 1'b0;
        end
      end
      S_HIGH: begin
        sram_addr_nxt = hw_lo | ADDR_W'(1);
        if (op_wr_nxt) begin
          dq_out_nxt = wdata_nxt[31:16];
          dq_oe_nxt  = 1'b1;
          we_n_nxt   = 1'b0;
        end else begin
          oe_n_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_wr   <= op_wr_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      sram_addr   <= sram_addr_nxt;
      sram_dq_out <= dq_out_nxt;
      sram_dq_oe  <= dq_oe_nxt;
      sram_we_n   <= we_n_nxt;
      sram_oe_n   <= oe_n_nxt;
    end
  end

  // Read data is sampled on the last cycle of each read phase; writes never touch it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
    end else begin
      if (capture_lo) read_data[15:0]  <= sram_dq_in;
      if (capture_hi) read_data[31:16] <= sram_dq_in;
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed timing scenarios plus randomized traffic
// checked against a word-level memory model of the external SRAM.
module tb_sram_controller;

  logic        clock;
  logic        reset;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n;

  logic        wr_en0, rd_en0;
  logic [31:0] address0, write_data0, read_data0;
  logic        ready0;
  logic [17:0] sram_addr0;
  logic [15:0] sram_dq_out0, sram_dq_in0;
  logic        sram_dq_oe0, sram_we_n0, sram_oe_n0;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap_cnt = 0;

  logic [15:0] sram1 [0:262143];
  logic [15:0] sram0 [0:262143];
  logic [15:0] ref_mem [int];

  logic        tr_ready [0:31];
  logic        tr_we    [0:31];
  logic        tr_oe    [0:31];
  logic [17:0] tr_addr  [0:31];
  logic [31:0] tr_rd    [0:31];

  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  sram_controller #(.ADDR_W(18), .WAIT_CYCLES(0), .BASE_ADDR(32'd1024)) dut0 (
    .clock(clock), .reset(reset), .wr_en(wr_en0), .rd_en(rd_en0),
    .address(address0), .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .sram_addr(sram_addr0), .sram_dq_out(sram_dq_out0), .sram_dq_in(sram_dq_in0),
    .sram_dq_oe(sram_dq_oe0), .sram_we_n(sram_we_n0), .sram_oe_n(sram_oe_n0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // External SRAM: asynchronous read, write sampled at the clock edge while we_n is low.
  assign sram_dq_in  = sram1[sram_addr];
  assign sram_dq_in0 = sram0[sram_addr0];

  initial begin
    for (int i = 0; i < 262144; i++) sram1[i] = 16'h0000;
    forever begin
      @(posedge clock);
      if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1) sram1[sram_addr] = sram_dq_out;
    end
  end

  initial begin
    for (int i = 0; i < 262144; i++) sram0[i] = 16'h0000;
    sram0[2] = 16'h3344;
    sram0[3] = 16'h1122;
  end

  always @(negedge clock) begin
    if ((sram_we_n === 1'b0 && sram_oe_n === 1'b0) || (sram_we_n0 === 1'b0 && sram_oe_n0 === 1'b0))
      overlap_cnt++;
  end

  // Reference mapping: half-word index of the low half of the word holding byte address a.
  function automatic int lo_hw(input logic [31:0] a);
    logic [31:0] w;
    w = (a - 32'd1024) / 4;
    return int'((w * 2) % 262144);
  endfunction

  function automatic logic [15:0] model_hw(input int i);
    return ref_mem.exists(i) ? ref_mem[i] : 16'h0000;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {model_hw(lo_hw(a) + 1), model_hw(lo_hw(a))};
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d);
    ref_mem[lo_hw(a)]     = d[15:0];
    ref_mem[lo_hw(a) + 1] = d[31:16];
  endtask

  // Holds a request from cycle 0 until ready is seen, recording each cycle's pins.
  task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
    for (int k = 0; k < 32; k++) begin
      tr_ready[k] = 1'bx; tr_we[k] = 1'bx; tr_oe[k] = 1'bx; tr_addr[k] = 'x; tr_rd[k] = 'x;
    end
    address = a; write_data = d; wr_en = wr; rd_en = rd;
    lat = -1;
    for (int k = 0; k < 32 && lat < 0; k++) begin
      @(negedge clock);
      tr_ready[k] = ready; tr_we[k] = sram_we_n; tr_oe[k] = sram_oe_n;
      tr_addr[k] = sram_addr; tr_rd[k] = read_data;
      if (ready === 1'b1) lat = k;
      @(posedge clock); #1;
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    wr_en = 0; rd_en = 0; address = 0; write_data = 0;
    wr_en0 = 0; rd_en0 = 0; address0 = 0; write_data0 = 0;
    #12;
    n_checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0)
      $display("FAIL reset_strobes: ready=%b we_n=%b oe_n=%b dq_oe=%b, want 1 1 1 0",
               ready, sram_we_n, sram_oe_n, sram_dq_oe);
    else n_pass++;
    n_checks++;
    if (read_data !== 32'h0 || sram_addr !== 18'h0 || sram_dq_out !== 16'h0)
      $display("FAIL reset_values: read_data=%h addr=%h dq_out=%h, want all zero",
               read_data, sram_addr, sram_dq_out);
    else n_pass++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_write;
    int lat;
    logic [31:0] prev_rd;
    prev_rd = read_data;
    do_access(1, 0, 32'd1024, 32'hDEADBEEF, lat);
    model_write(32'd1024, 32'hDEADBEEF);
    n_checks++;
    if (lat !== 5) $display("FAIL write_latency: got %0d want 5", lat); else n_pass++;
    for (int k = 0; k <= 5; k++) begin
      n_checks++;
      if (tr_ready[k] !== (k == 5) || tr_we[k] !== !(k >= 1 && k <= 4) || tr_oe[k] !== 1'b1 ||
          tr_rd[k] !== prev_rd)
        $display("FAIL write_cycle%0d: ready=%b we_n=%b oe_n=%b rd=%h, want %b %b 1 %h",
                 k, tr_ready[k], tr_we[k], tr_oe[k], tr_rd[k], (k == 5), !(k >= 1 && k <= 4), prev_rd);
      else n_pass++;
    end
    n_checks++;
    if (tr_addr[1] !== 18'd0 || tr_addr[2] !== 18'd0 || tr_addr[3] !== 18'd1 || tr_addr[4] !== 18'd1)
      $display("FAIL write_addr: %0d %0d %0d %0d want 0 0 1 1", tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]);
    else n_pass++;
    n_checks++;
    if (sram1[0] !== 16'hBEEF || sram1[1] !== 16'hDEAD)
      $display("FAIL write_mem: sram[0]=%h sram[1]=%h want beef dead", sram1[0], sram1[1]);
    else n_pass++;
  endtask

  task automatic test_read;
    int lat;
    do_access(0, 1, 32'd1024, 32'h0, lat);
    n_checks++;
    if (lat !== 5) $display("FAIL read_latency: got %0d want 5", lat); else n_pass++;
    for (int k = 0; k <= 5; k++) begin
      n_checks++;
      if (tr_oe[k] !== !(k >= 1 && k <= 4) || tr_we[k] !== 1'b1 || tr_ready[k] !== (k == 5))
        $display("FAIL read_cycle%0d: oe_n=%b we_n=%b ready=%b, want %b 1 %b",
                 k, tr_oe[k], tr_we[k], tr_ready[k], !(k >= 1 && k <= 4), (k == 5));
      else n_pass++;
    end
    n_checks++;
    if (tr_rd[5] !== model_word(32'd1024))
      $display("FAIL read_data: got %h want %h", tr_rd[5], model_word(32'd1024));
    else n_pass++;
  endtask

  task automatic test_wait0;
    int lat0;
    logic [17:0] a_tr [0:7];
    logic        o_tr [0:7];
    logic [31:0] rd_res;
    lat0 = -1; rd_res = 'x;
    for (int k = 0; k < 8; k++) begin a_tr[k] = 'x; o_tr[k] = 1'bx; end
    address0 = 32'd1028; rd_en0 = 1'b1;
    for (int k = 0; k < 8 && lat0 < 0; k++) begin
      @(negedge clock);
      a_tr[k] = sram_addr0; o_tr[k] = sram_oe_n0;
      if (ready0 === 1'b1) begin lat0 = k; rd_res = read_data0; end
      @(posedge clock); #1;
    end
    rd_en0 = 1'b0;
    n_checks++;
    if (lat0 !== 3) $display("FAIL wait0_latency: got %0d want 3", lat0); else n_pass++;
    n_checks++;
    if (a_tr[1] !== 18'd2 || a_tr[2] !== 18'd3 || o_tr[1] !== 1'b0 || o_tr[2] !== 1'b0)
      $display("FAIL wait0_addr: addr %0d %0d oe_n %b %b, want 2 3 0 0", a_tr[1], a_tr[2], o_tr[1], o_tr[2]);
    else n_pass++;
    n_checks++;
    if (rd_res !== 32'h11223344) $display("FAIL wait0_data: got %h want 11223344", rd_res); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat_w, lat_r;
    logic [31:0] d, prev_rd;
    bit rd_moved;
    d = $urandom;
    prev_rd = read_data;
    do_access(1, 0, 32'd1032, d, lat_w);
    model_write(32'd1032, d);
    rd_moved = 0;
    for (int k = 0; k <= 5; k++) if (tr_rd[k] !== prev_rd) rd_moved = 1;
    n_checks++;
    if (lat_w !== 5 || rd_moved)
      $display("FAIL b2b_write: lat=%0d read_data_changed=%0d, want 5 0", lat_w, rd_moved);
    else n_pass++;
    do_access(0, 1, 32'd1032, 32'h0, lat_r);
    n_checks++;
    if (lat_r !== 5 || tr_ready[0] !== 1'b0 || tr_oe[0] !== 1'b1 || tr_oe[1] !== 1'b0)
      $display("FAIL b2b_gap: lat=%0d ready0=%b oe_n0=%b oe_n1=%b, want 5 0 1 0",
               lat_r, tr_ready[0], tr_oe[0], tr_oe[1]);
    else n_pass++;
    n_checks++;
    if (tr_rd[5] !== d) $display("FAIL b2b_data: got %h want %h", tr_rd[5], d); else n_pass++;
  endtask

  task automatic test_both_requests;
    int lat;
    logic [31:0] prev_rd;
    bit oe_seen;
    prev_rd = read_data;
    do_access(1, 1, 32'd1024, 32'h12345678, lat);
    model_write(32'd1024, 32'h12345678);
    oe_seen = 0;
    for (int k = 0; k <= 5; k++) if (tr_oe[k] !== 1'b1) oe_seen = 1;
    n_checks++;
    if (sram1[0] !== 16'h5678 || sram1[1] !== 16'h1234 || oe_seen)
      $display("FAIL both_write: sram[0]=%h sram[1]=%h oe_seen=%0d, want 5678 1234 0",
               sram1[0], sram1[1], oe_seen);
    else n_pass++;
    n_checks++;
    if (lat !== 5 || tr_rd[5] !== prev_rd)
      $display("FAIL both_read_data: lat=%0d rd=%h, want 5 %h", lat, tr_rd[5], prev_rd);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat, lo;
    bit is_wr;
    logic [31:0] a, d, prev_rd;
    for (int n = 0; n < 40; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'd1024 + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      d = $urandom;
      prev_rd = read_data;
      do_access(is_wr, !is_wr, a, d, lat);
      n_checks++;
      if (lat !== 5) $display("FAIL rand%0d_latency: got %0d want 5", n, lat); else n_pass++;
      if (is_wr) begin
        model_write(a, d);
        lo = lo_hw(a);
        n_checks++;
        if (sram1[lo] !== model_hw(lo) || sram1[lo + 1] !== model_hw(lo + 1) || tr_rd[5] !== prev_rd)
          $display("FAIL rand%0d_write a=%h: sram=%h%h rd=%h, want %h%h %h", n, a,
                   sram1[lo + 1], sram1[lo], tr_rd[5], model_hw(lo + 1), model_hw(lo), prev_rd);
        else n_pass++;
      end else begin
        n_checks++;
        if (tr_rd[5] !== model_word(a))
          $display("FAIL rand%0d_read a=%h: got %h want %h", n, a, tr_rd[5], model_word(a));
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid;
    address = 32'd1024; write_data = 32'hCAFEF00D; wr_en = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (sram_we_n !== 1'b0 || sram_addr !== 18'd1)
      $display("FAIL midrst_pre: we_n=%b addr=%0d, want 0 1", sram_we_n, sram_addr);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0 ||
        sram_addr !== 18'd0 || sram_dq_out !== 16'd0)
      $display("FAIL midrst_abort: we_n=%b oe_n=%b dq_oe=%b addr=%0d dq_out=%h, want 1 1 0 0 0",
               sram_we_n, sram_oe_n, sram_dq_oe, sram_addr, sram_dq_out);
    else n_pass++;
    wr_en = 1'b0;
    ref_mem[0] = 16'hF00D;
    #1;
    n_checks++;
    if (ready !== 1'b1) $display("FAIL midrst_ready_in_reset: got %b want 1", ready); else n_pass++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    n_checks++;
    if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram1[1] !== model_hw(1))
      $display("FAIL midrst_release: ready=%b we_n=%b oe_n=%b sram[1]=%h, want 1 1 1 %h",
               ready, sram_we_n, sram_oe_n, sram1[1], model_hw(1));
    else n_pass++;
  endtask

  task automatic test_strobe_exclusive;
    n_checks++;
    if (overlap_cnt !== 0) $display("FAIL strobe_overlap: %0d cycles with we_n=oe_n=0, want 0", overlap_cnt);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wait0();
    test_back_to_back();
    test_both_requests();
    test_random();
    test_reset_mid();
    test_strobe_exclusive();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
